// File: rtl/fabric_timer_peripheral.sv
// Memory-mapped interval timer responding on one fabric master port.
// Four word registers (CTRL, LOAD, COUNT, STATUS), a fixed-latency
// request/ready handshake and a prescaled 32-bit down-counter that sets a
// sticky expiry flag and drives a level interrupt.
module fabric_timer_peripheral #(
    parameter int unsigned PRESCALE = 50,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [3:0]        byte_enable,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              ready,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_RELEASE
    } state_e;

    localparam logic [1:0]  REG_CTRL   = 2'd0;
    localparam logic [1:0]  REG_LOAD   = 2'd1;
    localparam logic [1:0]  REG_COUNT  = 2'd2;
    localparam logic [1:0]  REG_STATUS = 2'd3;
    localparam logic [15:0] PRESC_MAX  = 16'(PRESCALE - 1);

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic        ar_q, ar_d;
    logic        ie_q, ie_d;
    logic        expired_q, expired_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic [31:0] readdata_q, readdata_d;
    logic [15:0] presc_q, presc_d;

    logic        access;
    logic        wr_fire;
    logic        count_wr;
    logic        tick;
    logic [31:0] be_mask;
    logic [31:0] rd_mux;
    logic        unused_addr_hi;

    // Only the low two address bits select a register.
    assign unused_addr_hi = ^address[ADDR_W-1:2];

    assign wr_fire  = access & write;
    assign count_wr = wr_fire & (address[1:0] == REG_COUNT) & (|byte_enable);
    assign tick     = en_q & (presc_q == PRESC_MAX);

    assign ready    = (state_q == ST_ACK);
    assign readdata = readdata_q;
    assign irq      = expired_q & ie_q;

    // Expand byte enables into a 32-bit write mask.
    always_comb begin
        be_mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            be_mask[8*i +: 8] = {8{byte_enable[i]}};
        end
    end

    // Handshake: accept in IDLE, ack for one cycle, then wait for release.
    always_comb begin
        state_d = state_q;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (read || write) begin
                    access  = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK:     state_d = ST_RELEASE;
            ST_RELEASE: begin
                if (!read && !write) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Register read multiplexer.
    always_comb begin
        rd_mux = '0;
        case (address[1:0])
            REG_CTRL:   rd_mux = {29'd0, ie_q, ar_q, en_q};
            REG_LOAD:   rd_mux = load_q;
            REG_COUNT:  rd_mux = count_q;
            REG_STATUS: rd_mux = {31'd0, expired_q};
            default:    rd_mux = '0;
        endcase
    end

    // Timer and register next-state: timer events first, fabric writes
    // override them, and a fresh expiry overrides a STATUS clear.
    always_comb begin
        en_d       = en_q;
        ar_d       = ar_q;
        ie_d       = ie_q;
        load_d     = load_q;
        count_d    = count_q;
        expired_d  = expired_q;
        readdata_d = readdata_q;

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 32'd1;
            end else if (ar_q) begin
                count_d = load_q;
            end else begin
                en_d = 1'b0;
            end
        end

        if (wr_fire) begin
            case (address[1:0])
                REG_CTRL: begin
                    if (byte_enable[0]) begin
                        en_d = writedata[0];
                        ar_d = writedata[1];
                        ie_d = writedata[2];
                    end
                end
                REG_LOAD:   load_d  = (load_q & ~be_mask) | (writedata & be_mask);
                REG_COUNT:  count_d = (count_q & ~be_mask) | (writedata & be_mask);
                REG_STATUS: begin
                    if (byte_enable[0] && writedata[0]) begin
                        expired_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (tick && (count_q == '0)) begin
            expired_d = 1'b1;
        end

        if (access) begin
            readdata_d = write ? '0 : rd_mux;
        end
    end

    // Prescaler restarts whenever the timer is or becomes disabled, on a
    // COUNT write, and on each wrap.
    always_comb begin
        if (!en_q || !en_d || count_wr || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    // State and register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            ar_q       <= 1'b0;
            ie_q       <= 1'b0;
            expired_q  <= 1'b0;
            load_q     <= '0;
            count_q    <= '0;
            readdata_q <= '0;
            presc_q    <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            ar_q       <= ar_d;
            ie_q       <= ie_d;
            expired_q  <= expired_d;
            load_q     <= load_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
            presc_q    <= presc_d;
        end
    end

endmodule

// File: tb/tb_fabric_timer_peripheral.sv
// Self-checking bench for fabric_timer_peripheral with PRESCALE=4.
// Expected timer values come from tick arithmetic: with the counter enabled
// at edge a and COUNT=c, tick k lands on edge a+4k, so COUNT after edge a+m
// is c-floor(m/4) and expiry is at edge a+4(c+1).
module tb_fabric_timer_peripheral;

    localparam int unsigned PS = 4;
    localparam logic [1:0] A_CTRL = 2'd0, A_LOAD = 2'd1, A_COUNT = 2'd2, A_STATUS = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  address;
    logic [3:0]  byte_enable;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ready;
    logic        irq;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_load = '0;

    fabric_timer_peripheral #(.PRESCALE(PS), .ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .byte_enable(byte_enable),
        .read(read), .write(write), .writedata(writedata),
        .readdata(readdata), .ready(ready), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge two edges after the ack.
    task automatic bus(input logic do_rd, input logic do_wr, input logic [1:0] a,
                       input logic [3:0] be, input logic [31:0] wd,
                       output logic [31:0] rd, output int unsigned acc);
        address = {8'($urandom), a};
        read = do_rd; write = do_wr; byte_enable = be; writedata = wd;
        @(posedge clk); #1;
        acc = cyc;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL ack_latency reg=%0d got=%b want=1", a, ready); end
        rd = readdata;
        read = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL ack_width reg=%0d got=%b want=0", a, ready); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] wd, output int unsigned acc);
        logic [31:0] d;
        bus(1'b0, 1'b1, a, be, wd, d, acc);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        int unsigned acc;
        bus(1'b1, 1'b0, a, 4'hF, 32'h0, d, acc);
    endtask

    task automatic wait_to(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset();
        int unsigned a;
        logic [31:0] d;
        rst_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; byte_enable = '0; writedata = '0;
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", ready); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", irq); end
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata got=%h want=0", readdata); end
        rst_n = 1'b1;
        @(negedge clk);
        wr(A_LOAD, 4'hF, 32'h1234, a);
        wr(A_COUNT, 4'hF, 32'h0, a);
        wr(A_CTRL, 4'hF, 32'h5, a);
        wait_to(a + 4);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_rst_irq got=%b want=1", irq); end
        address = {8'h0, A_LOAD}; read = 1'b1;
        @(posedge clk); #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL pre_rst_ack got=%b want=1", ready); end
        rst_n = 1'b0; #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL midack_ready got=%b want=0", ready); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL midack_irq got=%b want=0", irq); end
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL midack_readdata got=%h want=0", readdata); end
        read = 1'b0;
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        m_load = '0;
        for (int r = 0; r < 4; r++) begin
            rd(2'(3 - r), d);
            total++; if (d !== 32'h0) begin bad++; $display("FAIL post_rst_reg%0d got=%h want=0", 3 - r, d); end
        end
    endtask

    task automatic test_byte_enable();
        int unsigned a;
        logic [31:0] d, wd;
        logic [3:0] be;
        wr(A_LOAD, 4'b0101, 32'hAABBCCDD, a);
        rd(A_LOAD, d);
        total++; if (d !== 32'h00BB00DD) begin bad++; $display("FAIL be_fixed got=%h want=00bb00dd", d); end
        m_load = 32'h00BB00DD;
        for (int k = 0; k < 6; k++) begin
            wd = $urandom; be = 4'($urandom);
            if (k == 0) be = 4'b0000;
            wr(A_LOAD, be, wd, a);
            for (int i = 0; i < 4; i++) if (be[i]) m_load[8*i +: 8] = wd[8*i +: 8];
            rd(A_LOAD, d);
            total++; if (d !== m_load) begin bad++; $display("FAIL be_rand be=%b got=%h want=%h", be, d, m_load); end
        end
    endtask

    task automatic test_held_write();
        int pulses = 0, first = -1;
        logic [31:0] d, w;
        w = $urandom;
        address = {8'h0, A_LOAD}; byte_enable = 4'hF; writedata = w; write = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) begin pulses++; if (first < 0) first = k; end
            if (k == 4) write = 1'b0;
        end
        @(negedge clk);
        m_load = w;
        total++; if (pulses != 1) begin bad++; $display("FAIL held_pulses got=%0d want=1", pulses); end
        total++; if (first != 0) begin bad++; $display("FAIL held_first got=%0d want=0", first); end
        rd(A_LOAD, d);
        total++; if (d !== m_load) begin bad++; $display("FAIL held_load got=%h want=%h", d, m_load); end
    endtask

    task automatic test_oneshot();
        int unsigned a;
        logic [31:0] d;
        wr(A_COUNT, 4'hF, 32'd3, a);
        wr(A_CTRL, 4'hF, 32'h5, a);
        wait_to(a + 15);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL os_irq_early got=%b want=0", irq); end
        wait_to(a + 16);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL os_irq got=%b want=1", irq); end
        rd(A_CTRL, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL os_ctrl got=%h want=4", d); end
        rd(A_COUNT, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL os_count got=%h want=0", d); end
        rd(A_STATUS, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL os_status got=%h want=1", d); end
        wr(A_STATUS, 4'h1, 32'h1, a);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL os_irq_clr got=%b want=0", irq); end
        rd(A_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL os_status_clr got=%h want=0", d); end
    endtask

    task automatic test_oneshot_random();
        int unsigned a, c, m, exp;
        logic [31:0] d;
        for (int k = 0; k < 3; k++) begin
            c = $urandom_range(6, 2);
            m = $urandom_range(4 * c, 4);
            wr(A_COUNT, 4'hF, c, a);
            wr(A_CTRL, 4'hF, 32'h5, a);
            wait_to(a + m - 1);
            rd(A_COUNT, d);
            exp = c - (m - 1) / PS;
            total++; if (d !== exp) begin bad++; $display("FAIL osr_count c=%0d m=%0d got=%0d want=%0d", c, m, d, exp); end
            wait_to(a + PS * c + 3);
            total++; if (irq !== 1'b0) begin bad++; $display("FAIL osr_irq_early c=%0d got=%b want=0", c, irq); end
            wait_to(a + PS * (c + 1));
            total++; if (irq !== 1'b1) begin bad++; $display("FAIL osr_irq c=%0d got=%b want=1", c, irq); end
            wr(A_STATUS, 4'h1, 32'h1, a);
        end
    endtask

    task automatic test_autoreload();
        int unsigned a, t;
        logic [31:0] d;
        wr(A_LOAD, 4'hF, 32'd2, t);
        m_load = 32'd2;
        wr(A_COUNT, 4'hF, 32'd0, t);
        wr(A_CTRL, 4'hF, 32'h7, a);
        wait_to(a + 3);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL ar_irq_early got=%b want=0", irq); end
        wait_to(a + 4);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL ar_irq1 got=%b want=1", irq); end
        wr(A_STATUS, 4'h1, 32'h1, t);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL ar_irq_clr got=%b want=0", irq); end
        rd(A_COUNT, d);
        total++; if (d !== 32'd2) begin bad++; $display("FAIL ar_reload got=%0d want=2", d); end
        wait_to(a + 15);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL ar_irq2_early got=%b want=0", irq); end
        wait_to(a + 16);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL ar_irq2 got=%b want=1", irq); end
        rd(A_CTRL, d);
        total++; if (d !== 32'h7) begin bad++; $display("FAIL ar_ctrl got=%h want=7", d); end
        wr(A_CTRL, 4'hF, 32'h0, t);
        wr(A_STATUS, 4'h1, 32'h1, t);
    endtask

    task automatic test_collisions();
        int unsigned a, t;
        logic [31:0] d;
        wr(A_COUNT, 4'hF, 32'd100, t);
        wr(A_CTRL, 4'hF, 32'h1, a);
        wait_to(a + 7);
        wr(A_COUNT, 4'hF, 32'd7, t);
        total++; if (t != a + 8) begin bad++; $display("FAIL col_count_edge got=%0d want=%0d", t - a, 8); end
        rd(A_COUNT, d);
        total++; if (d !== 32'd7) begin bad++; $display("FAIL col_count got=%0d want=7", d); end
        wr(A_CTRL, 4'hF, 32'h0, t);

        wr(A_COUNT, 4'hF, 32'd0, t);
        wr(A_CTRL, 4'hF, 32'h1, a);
        wait_to(a + 3);
        wr(A_STATUS, 4'h1, 32'h1, t);
        rd(A_STATUS, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL col_status got=%h want=1", d); end
        rd(A_CTRL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL col_autostop got=%h want=0", d); end
        wr(A_STATUS, 4'h1, 32'h1, t);

        wr(A_CTRL, 4'hF, 32'h1, a);
        wait_to(a + 3);
        wr(A_CTRL, 4'hF, 32'h1, t);
        rd(A_CTRL, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL col_ctrl got=%h want=1", d); end
        wr(A_CTRL, 4'hF, 32'h0, t);
        wr(A_STATUS, 4'h1, 32'h1, t);
    endtask

    task automatic test_priority();
        int unsigned a, t;
        logic [31:0] d;
        bus(1'b1, 1'b1, A_CTRL, 4'hF, 32'h1, d, a);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL prio_readdata got=%h want=0", d); end
        rd(A_CTRL, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL prio_ctrl got=%h want=1", d); end
        wr(A_CTRL, 4'hF, 32'h0, t);
        wr(A_STATUS, 4'h1, 32'h1, t);
        rd(A_LOAD, d);
        total++; if (d !== m_load) begin bad++; $display("FAIL prio_load got=%h want=%h", d, m_load); end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_held_write();
        test_oneshot();
        test_oneshot_random();
        test_autoreload();
        test_collisions();
        test_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
